// File: rtl/wave_table_loader_pkg.sv
// Shared wave-table constants and loader state encodings.
// Used by the write-side loader and by the playback reader.
package wave_table_loader_pkg;

  localparam int WAVE_DATA_W    = 8;
  localparam int WAVE_SAMPLE_AW = 12;
  localparam int WAVE_SLOT_AW   = 2;
  localparam int WAVE_SLOTS     = 1 << WAVE_SLOT_AW;
  localparam int WAVE_LEN       = 1 << WAVE_SAMPLE_AW;

  // Loader FSM encodings, kept as plain constants so older tools can read them
  localparam logic [1:0] LD_IDLE = 2'd0;
  localparam logic [1:0] LD_LOAD = 2'd1;
  localparam logic [1:0] LD_DONE = 2'd2;
  localparam logic [1:0] LD_ERR  = 2'd3;

  // Flat RAM address of a sample inside a slot
  function automatic logic [WAVE_SLOT_AW+WAVE_SAMPLE_AW-1:0] waveAddr(
    input logic [WAVE_SLOT_AW-1:0]   slotSel,
    input logic [WAVE_SAMPLE_AW-1:0] sampleIdx
  );
    return {slotSel, sampleIdx};
  endfunction

endpackage

// File: rtl/wave_table_loader_timeout_cnt.sv
// Idle-cycle counter for the loader: synchronous clear has priority over
// enable, and o_tc flags the count value TERM-1.
module loader_timeout_cnt #(
  parameter int TERM = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CW = (TERM > 1) ? $clog2(TERM) : 1;

  logic [CW-1:0] r_count;

  // Count idle cycles; clear wins so a beat always restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == CW'(TERM - 1));

endmodule

// File: rtl/wave_table_loader.sv
// Write-side wave-table loader: takes a valid/ready byte stream and writes
// exactly one 4096-sample slot of the wave RAM, with an idle timeout abort.
// Optional running checksum of the loaded bytes is enabled by defining
// LOADER_CHECKSUM_EN; otherwise checksum is tied to zero.
module wave_table_loader
  import wave_table_loader_pkg::*;
#(
  parameter int DATA_W      = WAVE_DATA_W,
  parameter int SAMPLE_AW   = WAVE_SAMPLE_AW,
  parameter int SLOT_AW     = WAVE_SLOT_AW,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [SLOT_AW-1:0]           slot,
  input  logic                         s_valid,
  input  logic [DATA_W-1:0]            s_data,
  output logic                         s_ready,
  output logic                         wr_en,
  output logic [SLOT_AW+SAMPLE_AW-1:0] wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [15:0]                  checksum
);

  logic [1:0]                   r_state;
  logic [1:0]                   w_stateNext;
  logic [SLOT_AW-1:0]           r_slotQ;
  logic [SAMPLE_AW-1:0]         r_cnt;
  logic                         r_wrEn;
  logic [SLOT_AW+SAMPLE_AW-1:0] r_wrAddr;
  logic [DATA_W-1:0]            r_wrData;

  logic w_sReady;
  logic w_beat;
  logic w_lastBeat;
  logic w_accept;
  logic w_toClear;
  logic w_toEnable;
  logic w_toTc;

  assign w_sReady   = (r_state == LD_LOAD);
  assign w_beat     = s_valid && w_sReady;
  assign w_lastBeat = w_beat && (r_cnt == {SAMPLE_AW{1'b1}});
  assign w_accept   = (r_state == LD_IDLE) && start;

  // Idle window restarts on every beat and is held at zero outside LOAD
  assign w_toClear  = (r_state != LD_LOAD) || w_beat;
  assign w_toEnable = (r_state == LD_LOAD) && !w_beat;

  loader_timeout_cnt #(
    .TERM (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_toClear),
    .i_enable (w_toEnable),
    .o_tc     (w_toTc)
  );

  // Next-state decode; DONE and ERR each last one cycle and ignore start
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      LD_IDLE: if (start) w_stateNext = LD_LOAD;
      LD_LOAD: begin
        if (w_lastBeat) begin
          w_stateNext = LD_DONE;
        end else if (!w_beat && w_toTc) begin
          w_stateNext = LD_ERR;
        end
      end
      LD_DONE: w_stateNext = LD_IDLE;
      LD_ERR:  w_stateNext = LD_IDLE;
      default: w_stateNext = LD_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Target slot latch and sample counter; the counter wraps to 0 on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slotQ <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_slotQ <= slot;
      r_cnt   <= '0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // RAM write port, one cycle behind the handshake; address/data hold between beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrEn   <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
    end else begin
      r_wrEn <= w_beat;
      if (w_beat) begin
        r_wrAddr <= waveAddr(r_slotQ, r_cnt);
        r_wrData <= s_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_acc;
  logic [15:0] r_checksum;

  // Running sum of the accepted bytes; published only when the slot completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= '0;
      end else if (w_beat) begin
        r_acc <= r_acc + 16'(s_data);
      end
      if (w_lastBeat) begin
        r_checksum <= r_acc + 16'(s_data);
      end
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 16'd0;
`endif

  assign s_ready = w_sReady;
  assign wr_en   = r_wrEn;
  assign wr_addr = r_wrAddr;
  assign wr_data = r_wrData;
  assign busy    = (r_state != LD_IDLE);
  assign done    = (r_state == LD_DONE);
  assign err     = (r_state == LD_ERR);

endmodule

// File: tb/tb_wave_table_loader.sv
// Self-checking bench for wave_table_loader: a directed vector table, directed
// multi-cycle sequences and a randomized run, all compared cycle by cycle
// against a transaction-level model of the loader.
module tb_wave_table_loader;

  localparam int TB_TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  slot;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  wave_table_loader #(
    .DATA_W      (8),
    .SAMPLE_AW   (12),
    .SLOT_AW     (2),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .slot     (slot),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sReady;
    logic        wrEn;
    logic [13:0] wrAddr;
    logic [7:0]  wrData;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;
  } outs_t;

  typedef struct packed {
    logic        start;
    logic [1:0]  slot;
    logic        valid;
    logic [7:0]  data;
    logic        expReady;
    logic        expWr;
    logic [13:0] expAddr;
    logic [7:0]  expData;
    logic        expBusy;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  // Model: a load is a slot plus the number of bytes taken so far
  bit          mLoading;
  bit          mDone;
  bit          mErr;
  bit          mWr;
  int          mSlot;
  int          mCount;
  int          mIdle;
  logic [13:0] mAddr;
  logic [7:0]  mData;
  logic [15:0] mSum;
  logic [15:0] mChk;

  // Observations of the DUT used by the explicit sequence checks
  int cycleNo;
  int obsWrCount;
  int obsLastAddr;
  int obsLastWrCycle;
  int obsErrCycle;
  int obsDoneAddr;
  int obsFirstAddr;

  outs_t dutOut;
  assign dutOut = '{s_ready, wr_en, wr_addr, wr_data, busy, done, err, checksum};

  task automatic modelReset();
    mLoading = 0; mDone = 0; mErr = 0; mWr = 0;
    mSlot = 0; mCount = 0; mIdle = 0;
    mAddr = '0; mData = '0; mSum = '0; mChk = '0;
  endtask

  function automatic outs_t modelOut();
    outs_t o;
    o.sReady = mLoading;
    o.wrEn   = mWr;
    o.wrAddr = mAddr;
    o.wrData = mData;
    o.busy   = mLoading || mDone || mErr;
    o.done   = mDone;
    o.err    = mErr;
`ifdef LOADER_CHECKSUM_EN
    o.checksum = mChk;
`else
    o.checksum = 16'd0;
`endif
    return o;
  endfunction

  // One clock of the model, given the inputs that were presented
  task automatic modelAdvance(input bit st, input int sl, input bit v, input logic [7:0] d);
    bit beat;
    bit wasIdle;
    beat    = mLoading && v;
    wasIdle = !mLoading && !mDone && !mErr;
    mWr = beat;
    if (beat) begin
      mAddr = 14'(mSlot * 4096 + mCount);
      mData = d;
      mSum  = mSum + 16'(d);
    end
    mDone = 0;
    mErr  = 0;
    if (mLoading) begin
      if (beat) begin
        mCount++;
        mIdle = 0;
        if (mCount == 4096) begin
          mLoading = 0;
          mDone    = 1;
          mChk     = mSum;
          mCount   = 0;
        end
      end else begin
        mIdle++;
        if (mIdle == TB_TIMEOUT) begin
          mLoading = 0;
          mErr     = 1;
        end
      end
    end else if (wasIdle && st) begin
      mLoading = 1;
      mSlot    = sl;
      mCount   = 0;
      mIdle    = 0;
      mSum     = '0;
    end
  endtask

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @cycle %0d: got %h expected %h", name, cycleNo, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Record write/err activity seen in the current cycle
  task automatic observe();
    if (wr_en === 1'b1) begin
      if (obsWrCount == 0) obsFirstAddr = int'(wr_addr);
      obsWrCount++;
      obsLastAddr    = int'(wr_addr);
      obsLastWrCycle = cycleNo;
      if (done === 1'b1) obsDoneAddr = int'(wr_addr);
    end
    if (err === 1'b1) obsErrCycle = cycleNo;
  endtask

  task automatic clearObs();
    obsWrCount = 0; obsLastAddr = -1; obsLastWrCycle = -1;
    obsErrCycle = -1; obsDoneAddr = -1; obsFirstAddr = -1;
  endtask

  // Drive one cycle of inputs, compare against the model, then advance it
  task automatic applyStimulus(input bit st, input logic [1:0] sl, input bit v, input logic [7:0] d);
    @(negedge clk);
    start = st; slot = sl; s_valid = v; s_data = d;
    cycleNo++;
    checkOutput("cycle", dutOut, modelOut());
    observe();
    @(posedge clk);
    modelAdvance(st, int'(sl), v, d);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge
  task automatic doReset();
    @(negedge clk);
    start = 0; slot = 0; s_valid = 0; s_data = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", dutOut, '0);
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[9];

  initial begin
    rst_n = 1'b0; start = 0; slot = 0; s_valid = 0; s_data = 0;
    cycleNo = 0;
    modelReset();
    clearObs();

    vecs[0] = '{1'b0, 2'd0, 1'b1, 8'hAA, 1'b0, 1'b0, 14'd0,    8'h00, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 14'd0,    8'h00, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 14'd0,    8'h00, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 1'b1, 8'h5A, 1'b1, 1'b0, 14'd0,    8'h00, 1'b1};
    vecs[4] = '{1'b0, 2'd0, 1'b1, 8'h3C, 1'b1, 1'b1, 14'd4096, 8'h5A, 1'b1};
    vecs[5] = '{1'b0, 2'd3, 1'b0, 8'h00, 1'b1, 1'b1, 14'd4097, 8'h3C, 1'b1};
    vecs[6] = '{1'b1, 2'd3, 1'b0, 8'h00, 1'b1, 1'b0, 14'd4097, 8'h3C, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 1'b1, 8'h77, 1'b1, 1'b0, 14'd4097, 8'h3C, 1'b1};
    vecs[8] = '{1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 14'd4098, 8'h77, 1'b1};

    // Reset state while held in reset
    repeat (3) @(negedge clk);
    checkOutput("reset_state", dutOut, '0);
    rst_n = 1'b1;

    // Directed vector table: idle behaviour, start, first writes, ignored start
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = vecs[i].start; slot = vecs[i].slot;
      s_valid = vecs[i].valid; s_data = vecs[i].data;
      cycleNo++;
      compared++;
      if ({s_ready, wr_en, wr_addr, wr_data, busy} !==
          {vecs[i].expReady, vecs[i].expWr, vecs[i].expAddr, vecs[i].expData, vecs[i].expBusy}) begin
        mismatched++;
        $display("[TB] FAIL vec%0d: got rdy=%b wr=%b addr=%0d data=%h busy=%b expected rdy=%b wr=%b addr=%0d data=%h busy=%b",
                 i, s_ready, wr_en, wr_addr, wr_data, busy, vecs[i].expReady, vecs[i].expWr,
                 vecs[i].expAddr, vecs[i].expData, vecs[i].expBusy);
      end
      @(posedge clk);
    end
    doReset();

    // Slot 2, 4096 back-to-back bytes, then bytes offered after done
    clearObs();
    applyStimulus(1'b1, 2'd2, 1'b0, 8'h00);
    for (int i = 0; i < 4096; i++) applyStimulus(1'b0, 2'd0, 1'b1, 8'(i));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd0, 1'b1, 8'($urandom));
    checkValue("slot2_wr_count", obsWrCount, 4096);
    checkValue("slot2_first_addr", obsFirstAddr, 8192);
    checkValue("slot2_done_addr", obsDoneAddr, 12287);
`ifdef LOADER_CHECKSUM_EN
    checkValue("slot2_checksum", int'(checksum), 32'hF800);
`else
    checkValue("slot2_checksum", int'(checksum), 0);
`endif

    // Slot 3 with s_valid toggling and a start attempt mid-load
    clearObs();
    applyStimulus(1'b1, 2'd3, 1'b0, 8'h00);
    for (int i = 0; i < 8200; i++) begin
      applyStimulus((i == 1000), 2'd0, (i % 2 == 0), 8'($urandom));
    end
    checkValue("slot3_wr_count", obsWrCount, 4096);
    checkValue("slot3_last_addr", obsLastAddr, 16383);

    // Timeout: slot 1, 100 bytes, then the stream goes quiet
    clearObs();
    applyStimulus(1'b1, 2'd1, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 2'd0, 1'b1, 8'($urandom));
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);
    checkValue("to_wr_count", obsWrCount, 100);
    checkValue("to_last_addr", obsLastAddr, 4195);
    checkValue("to_err_delay", obsErrCycle - obsLastWrCycle, TB_TIMEOUT);
    checkValue("to_idle_busy", int'(busy), 0);

    // Reset in the middle of a slot-0 load, then restart the same slot
    applyStimulus(1'b1, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 2'd0, 1'b1, 8'($urandom));
    doReset();
    clearObs();
    applyStimulus(1'b1, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd0, 1'b1, 8'($urandom));
    applyStimulus(1'b0, 2'd0, 1'b0, 8'h00);
    checkValue("restart_first_addr", obsFirstAddr, 0);
    checkValue("restart_wr_count", obsWrCount, 5);

    // Randomized traffic: random starts, valid density and occasional long gaps
    begin
      int gapLeft;
      bit v;
      gapLeft = 0;
      for (int i = 0; i < 15000; i++) begin
        if (gapLeft > 0) begin
          v = 1'b0;
          gapLeft--;
        end else begin
          if ($urandom_range(0, 2999) == 0) gapLeft = 20;
          v = ($urandom_range(0, 3) != 0);
        end
        applyStimulus(($urandom_range(0, 39) == 0), 2'($urandom), v, 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
